multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the PCIM core. Sequences FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/opcode_class_dec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control path: opcodes, FSM states,
// ALU operation codes and the decoded instruction class.
package ctrl_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [2:0] {
    LW,
    SW,
    RADD,
    RSUB,
    RAND,
    ROR,
    RSLT,
    ILL
  } op_class_t;

  // ALU operation for an instruction class; loads and stores use ADD for
  // address generation.
  function automatic logic [2:0] class_alu_op(input op_class_t c);
    case (c)
      RSUB:    return ALU_SUB;
      RAND:    return ALU_AND;
      ROR:     return ALU_OR;
      RSLT:    return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: 6-bit opcode -> instruction class and a
// legal flag. Kept standalone so the ID stage can reuse it.
module opcode_class_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       legal
);

  // Map each defined opcode to its class; anything else is illegal.
  always_comb begin
    op_class = ILL;
    legal    = 1'b1;
    case (opcode)
      OP_LW:   op_class = LW;
      OP_SW:   op_class = SW;
      OP_ADD:  op_class = RADD;
      OP_SUB:  op_class = RSUB;
      OP_AND:  op_class = RAND;
      OP_OR:   op_class = ROR;
      OP_SLT:  op_class = RSLT;
      default: begin
        op_class = ILL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables, guards memory waits with a timeout and counts retired
// instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  state_t           state_next;
  op_class_t        cls;
  op_class_t        dec_class;
  logic             dec_legal;
  logic [TO_W-1:0]  to_cnt;
  logic             waiting;
  logic             timeout;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  logic             unused_instr_bits;

  // Only the opcode field matters to control.
  assign unused_instr_bits = ^instr_in[25:0];

  opcode_class_dec u_dec (
    .opcode   (instr_in[31:26]),
    .op_class (dec_class),
    .legal    (dec_legal)
  );

  // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle; mem_ready wins.
  assign waiting = (state == FETCH) || (state == MEM);
  assign timeout = waiting && !mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Latch the instruction class once in DECODE so later IR changes are ignored.
  always_ff @(posedge clk) begin
    if (state == DECODE) cls <= dec_class;
  end

  // Wait counter: runs only while stalled in FETCH/MEM, zero everywhere else,
  // so every entry into FETCH or MEM starts from zero.
  always_ff @(posedge clk) begin
    if (rst)                              to_cnt <= '0;
    else if (waiting && !mem_ready && !timeout) to_cnt <= to_cnt + 1'b1;
    else                                  to_cnt <= '0;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign retired = rst ? '0 : retired_q;

  // Next-state and output decode; reset forces every enable low.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_write   = 1'b1;
          ir_write   = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = FETCH;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          state_next = EXEC;
        end else begin
          illegal    = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC: begin
        alu_op = class_alu_op(cls);
        if (cls == LW || cls == SW) begin
          alu_src_b  = 1'b1;
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        alu_op = class_alu_op(cls);
        if (cls == SW) mem_write = 1'b1;
        else           mem_read  = 1'b1;
        if (mem_ready) begin
          if (cls == SW) begin
            instr_done = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        alu_op     = class_alu_op(cls);
        reg_write  = 1'b1;
        mem_to_reg = (cls == LW);
        instr_done = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the hand-computed
// per-cycle output vector, a monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, alu_src_b;
  logic [2:0]  alu_op;
  logic        reg_write, mem_to_reg, instr_done, illegal, mem_err;
  logic [1:0]  retired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] I_ADD = {6'b100000, 26'h0123456};
  localparam logic [31:0] I_SUB = {6'b100010, 26'h3ffffff};
  localparam logic [31:0] I_AND = {6'b100100, 26'h0000001};
  localparam logic [31:0] I_OR  = {6'b100101, 26'h2aaaaaa};
  localparam logic [31:0] I_SLT = {6'b101010, 26'h1555555};
  localparam logic [31:0] I_LW  = {6'b100011, 26'h0000040};
  localparam logic [31:0] I_SW  = {6'b101011, 26'h0000080};
  localparam logic [31:0] I_BAD = {6'b111111, 26'h0};

  multicycle_ctrl #(.TO_W(8), .MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal),
    .mem_err    (mem_err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Vector layout: pcw irw mr mw asb aop[2:0] rw m2r done ill err ret[1:0]
  function automatic logic [14:0] v(input bit pcw, input bit irw, input bit mr,
                                    input bit mw, input bit asb, input logic [2:0] aop,
                                    input bit rw, input bit m2r, input bit done,
                                    input bit ill, input bit err, input logic [1:0] ret);
    return {pcw, irw, mr, mw, asb, aop, rw, m2r, done, ill, err, ret};
  endfunction

  task automatic step(input string name, input logic r, input logic [31:0] ins,
                      input logic rdy, input logic [14:0] e);
    exp_t item;
    rst       = r;
    instr_in  = ins;
    mem_ready = rdy;
    item.name = name;
    item.v    = e;
    exp_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    exp_t        item;
    logic [14:0] act;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      act  = {pc_write, ir_write, mem_read, mem_write, alu_src_b, alu_op,
              reg_write, mem_to_reg, instr_done, illegal, mem_err, retired};
      n_cmp++;
      if (act !== item.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (pcw irw mr mw asb aop rw m2r done ill err ret)",
                 item.name, act, item.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rops [5];
    logic [2:0]  raop [5];
    logic [1:0]  r;
    rops = '{I_ADD, I_SUB, I_AND, I_OR, I_SLT};
    raop = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

    @(posedge clk);
    #1;
    // Reset: everything low.
    step("reset0", 1, I_ADD, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd0));
    step("reset1", 1, I_ADD, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd0));

    // R-type ops, mem_ready held high; retired wraps 3->0 after the OR.
    for (int i = 0; i < 5; i++) begin
      r = 2'(i);
      step("rop_fetch", 0, rops[i], 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,r));
      step("rop_decode", 0, rops[i], 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,r));
      step("rop_exec", 0, rops[i], 1, v(0,0,0,0,0,raop[i],0,0,0,0,0,r));
      step("rop_wb", 0, rops[i], 1, v(0,0,0,0,0,raop[i],1,0,1,0,0,r));
    end

    // lw with 3 stall cycles in MEM; IR changes after DECODE are ignored.
    step("lw_fetch", 0, I_LW, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_decode", 0, I_LW, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_exec", 0, I_SUB, 1, v(0,0,0,0,1,3'b000,0,0,0,0,0,2'd1));
    step("lw_mem_w1", 0, I_SUB, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_mem_w2", 0, I_SUB, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_mem_w3", 0, I_SUB, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_mem_rdy", 0, I_SUB, 1, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd1));
    step("lw_wb", 0, I_SUB, 1, v(0,0,0,0,0,3'b000,1,1,1,0,0,2'd1));

    // sw: retires out of MEM, never writes the register file.
    step("sw_fetch", 0, I_SW, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd2));
    step("sw_decode", 0, I_SW, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd2));
    step("sw_exec", 0, I_SW, 1, v(0,0,0,0,1,3'b000,0,0,0,0,0,2'd2));
    step("sw_mem", 0, I_SW, 1, v(0,0,0,1,0,3'b000,0,0,1,0,0,2'd2));

    // Illegal opcode: pulse in DECODE, straight back to FETCH, not retired.
    step("ill_fetch", 0, I_BAD, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("ill_decode", 0, I_BAD, 1, v(0,0,0,0,0,3'b000,0,0,0,1,0,2'd3));

    // lw timing out in MEM: mem_err on the 4th wait, no writeback.
    step("lwto_fetch", 0, I_LW, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("lwto_decode", 0, I_LW, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd3));
    step("lwto_exec", 0, I_LW, 1, v(0,0,0,0,1,3'b000,0,0,0,0,0,2'd3));
    step("lwto_w1", 0, I_LW, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("lwto_w2", 0, I_LW, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("lwto_w3", 0, I_LW, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("lwto_err", 0, I_LW, 0, v(0,0,1,0,0,3'b000,0,0,0,0,1,2'd3));

    // Reset in MEM of lw: abort, FETCH next, retired cleared.
    step("rstlw_fetch", 0, I_LW, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("rstlw_decode", 0, I_LW, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd3));
    step("rstlw_exec", 0, I_LW, 1, v(0,0,0,0,1,3'b000,0,0,0,0,0,2'd3));
    step("rstlw_mem", 0, I_LW, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd3));
    step("rstlw_rst", 1, I_LW, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd0));

    // FETCH timeout after reset, then FETCH re-entered and mem_ready on the 4th cycle.
    step("fto_w1", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto_w2", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto_w3", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto_err", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,1,2'd0));
    step("fto2_w1", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_w2", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_w3", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_rdy", 0, I_ADD, 1, v(1,1,1,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_decode", 0, I_ADD, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_exec", 0, I_ADD, 1, v(0,0,0,0,0,3'b000,0,0,0,0,0,2'd0));
    step("fto2_wb", 0, I_ADD, 1, v(0,0,0,0,0,3'b000,1,0,1,0,0,2'd0));
    step("final_fetch", 0, I_ADD, 0, v(0,0,1,0,0,3'b000,0,0,0,0,0,2'd1));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
